// File: rtl/mem_dma.sv
// Byte-wise block copy engine driving a single-port data memory (comb read, sync write).
// Optional fill mode (constant pattern written to dst range) enabled by defining MEM_DMA_FILL_EN.
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              done,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_DMA_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] data_q;
  logic              fill_mode;
  logic [DATA_W-1:0] wr_data;

`ifdef MEM_DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] pattern_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q    <= fill;
      pattern_q <= pattern;
    end
  end

  assign fill_mode = fill_q;
  assign wr_data   = fill_q ? pattern_q : data_q;
`else
  assign fill_mode = 1'b0;
  assign wr_data   = data_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            cnt     <= len;
          end
        end
        RD: data_q <= mem_dout;
        WR: begin
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          cnt     <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == 8'd0) begin
            state_nx = DONE;
          end else begin
`ifdef MEM_DMA_FILL_EN
            state_nx = fill ? WR : RD;
`else
            state_nx = RD;
`endif
          end
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_addr = src_ptr;
        state_nx = WR;
      end
      WR: begin
        busy      = 1'b1;
        // Gated by rst_n so a reset landing on a WR cycle suppresses its write.
        mem_write = rst_n;
        mem_addr  = dst_ptr;
        mem_din   = wr_data;
        if (cnt == 8'd1) begin
          state_nx = DONE;
        end else begin
          state_nx = fill_mode ? WR : RD;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Block-copy engine that acts as the initiator on the 8-bit data memory port. It moves `len` bytes from a source address range to a destination address range through the memory's single shared port. The memory has a combinational read and a synchronous write on `clk`. The engine sits between the control logic and the data memory, and it owns the memory's `write`/`addr`/`din` inputs while busy.

## Interface
- ADDR_W, 8, memory address width (256 locations)
- DATA_W, 8, memory data width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only in IDLE
- src  in  ADDR_W  first source address; latched on accept
- dst  in  ADDR_W  first destination address; latched on accept
- len  in  8  byte count, 0..255; latched on accept
- busy  out  1  high in RD and WR states
- done  out  1  one-cycle pulse on completion
- mem_write  out  1  to memory `write`
- mem_addr  out  ADDR_W  to memory `addr`
- mem_din  out  DATA_W  to memory `din`
- mem_dout  in  DATA_W  from memory `dout`; combinational read data
- fill  in  1  (only with MEM_DMA_FILL_EN) select fill mode; latched on accept
- pattern  in  DATA_W  (only with MEM_DMA_FILL_EN) fill byte; latched on accept

## Operation
- The FSM has four states: IDLE, RD, WR, DONE. Reset enters IDLE.
- Registers: src_ptr, dst_ptr, cnt (8 bit), data_q (8 bit).
- IDLE: if `start`=1, latch src/dst/len into src_ptr/dst_ptr/cnt.
  - len=0 → DONE.
  - len≠0 → RD.
- RD:
  - Drives mem_addr=src_ptr and mem_write=0.
  - At the edge: data_q ← mem_dout, then → WR.
- WR:
  - Drives mem_addr=dst_ptr, mem_din=data_q, mem_write=1.
  - At the edge: src_ptr+1, dst_ptr+1, cnt−1.
  - If cnt was 1 → DONE, else → RD.
- DONE: drives done=1 for exactly one cycle, then → IDLE.
- Outside WR: mem_write=0, mem_addr=0, mem_din=0.
- Pointers wrap modulo 256 (255+1=0). No error is raised on wrap.
- Overlapping ranges:
  - Copy is strictly forward and byte-at-a-time.
  - If dst is in (src, src+len), already-written bytes are re-read. The spec requires this replicating behaviour; it is not an error.
- `start` in RD/WR/DONE is ignored. It is not queued.
- Any change on src/dst/len after accept has no effect.

## Timing
- Reset values: busy=0, done=0, mem_write=0, mem_addr=0, mem_din=0, state=IDLE. data_q, pointers and cnt are also cleared to 0.
- Reset mid-transfer: at the first edge with rst_n=0, all outputs return to reset values in the following cycle.
  - Any in-flight WR cycle is abandoned with no write. Memory keeps the bytes already written.
  - No done pulse is produced.
- Accept edge = edge E0 where IDLE and start=1.
- Copy of len=N≥1:
  - RD occupies cycle 2k+1 after E0 and WR occupies cycle 2k+2, for k=0..N−1.
  - DONE is cycle 2N+1, so done is high in that cycle.
  - A new start is sampled no earlier than the edge ending cycle 2N+2 (first IDLE cycle).
- len=0: done is high in cycle 1 after E0, busy never rises, and no memory write occurs.
- Memory read latency is zero within the cycle. data_q captures mem_dout at the end of RD.

## Configuration
- Macro: MEM_DMA_FILL_EN.
- Defined:
  - The `fill` and `pattern` ports exist.
  - If fill=1 at accept, the FSM skips RD. Each byte is one WR cycle with mem_din=pattern and dst_ptr incrementing, while src is ignored.
  - done comes in cycle N+1 after E0.
  - fill=0 behaves as a plain copy.
- Not defined: the ports are absent and the engine is copy-only. No fill logic is synthesised.

## Test plan
- Preload mem[254]=17, mem[255]=23; start src=254, dst=0, len=2 → mem[0]=17, mem[1]=23; mem_write high in cycles 2 and 4 only; done high in cycle 5.
- Wrap: mem[255]=0xAA, mem[0]=0x55; src=255, dst=16, len=2 → reads addr 255 then 0; mem[16]=0xAA, mem[17]=0x55.
- len=0, dst=8 → done in cycle 1; busy stays 0; no mem_write; mem[8] unchanged.
- Overlap: mem[10]=0x3C; src=10, dst=11, len=4 → mem[11..14] all 0x3C.
- start held high through an entire len=3 copy → only one transfer; after DONE with start still high, a second transfer begins from the first IDLE cycle.
- rst_n=0 during the second WR of a len=4 copy from 0→100 → mem[100] written, mem[101..103] unchanged, done never pulses.
- (MEM_DMA_FILL_EN) fill=1, pattern=0xFF, dst=250, len=8 → mem[250..255] and mem[0..1]=0xFF; done in cycle 9.
